serv_dbus_axi_bridge: RTL and testbench
=======================================

# serv_dbus_axi_bridge

Converts the SERV core's Wishbone-classic data bus (`o_dbus_*` / `i_dbus_*` of the SERV toplevel) into single-beat AXI4 master transactions for the system interconnect. Sits directly downstream of the SERV toplevel's data port, one instance per core. Handles exactly one outstanding access at a time, which matches SERV's blocking load/store behaviour.

## Interface
- `ID_WIDTH`, 4: width of the AXI ID fields.
- `AXI_ID`, 0: constant value driven on `m_axi_awid` and `m_axi_arid`.
- `clk` input 1: clock. All logic is on the rising edge.
- `i_rst` input 1: reset. Synchronous and active-high.
- `i_wb_adr` input 32: byte address from SERV.
- `i_wb_dat` input 32: store data.
- `i_wb_sel` input 4: byte enables.
- `i_wb_we` input 1: 1 = store, 0 = load.
- `i_wb_cyc` input 1: request, held high until ack.
- `o_wb_rdt` output 32: load data. Valid in the ack cycle and held until the next read completes.
- `o_wb_ack` output 1: single-cycle completion pulse.
- `o_bus_err` output 1: pulses together with `o_wb_ack` when the response is not OKAY.
- `m_axi_awid/awaddr/awlen/awsize/awburst/awprot/awvalid` output; `m_axi_awready` input: AXI4 write-address channel.
- `m_axi_wdata/wstrb/wlast/wvalid` output; `m_axi_wready` input: write-data channel.
- `m_axi_bresp[1:0]/bvalid` input; `m_axi_bready` output: write-response channel.
- `m_axi_arid/araddr/arlen/arsize/arburst/arprot/arvalid` output; `m_axi_arready` input: read-address channel.
- `m_axi_rdata[31:0]/rresp[1:0]/rlast/rvalid` input; `m_axi_rready` output: read-data channel.

## Operation

**Constant fields**
- `awlen` = `arlen` = 0.
- `awsize` = `arsize` = 3'b010.
- `awburst` = `arburst` = 2'b01 (INCR).
- `awprot` = `arprot` = 3'b000.
- `wlast` = 1.
- IDs = `AXI_ID`.

**Request capture** (in IDLE, on the edge where `i_wb_cyc` = 1)
- Address is registered as `{i_wb_adr[31:2], 2'b00}`.
- `i_wb_dat` and `i_wb_sel` are registered to `wdata` and `wstrb`.
- Registered values stay stable until the transaction completes.

**FSM states:** IDLE, WADDR_DATA, WRESP, RADDR, RDATA, ACK.
- IDLE, `cyc` & `we` -> WADDR_DATA; `awvalid` = `wvalid` = 1.
- IDLE, `cyc` & !`we` -> RADDR; `arvalid` = 1.
- WADDR_DATA:
  - `awvalid` clears on the `awready` handshake; `wvalid` clears on the `wready` handshake. The two complete independently, in either order or together.
  - When both have completed -> WRESP.
  - Neither valid is ever dropped before its handshake.
- WRESP: `bready` = 1. On `bvalid` -> ACK, with `o_wb_ack` = 1 and `o_bus_err` = (`bresp` != 0).
- RADDR: on `arready` -> RDATA, deasserting `arvalid`.
- RDATA: `rready` = 1. On `rvalid` -> ACK, with `o_wb_rdt` = `rdata`, `o_wb_ack` = 1 and `o_bus_err` = (`rresp` != 0).
- ACK: unconditionally -> IDLE. This one-cycle guard stops the still-high `cyc` from retriggering, since SERV drops `cyc` the cycle after ack.

**Error handling**
- SLVERR/DECERR responses still complete the access, and `rdata` is forwarded unchanged.
- The bridge does not retry.

**Input handling**
- `i_wb_*` is ignored outside IDLE.
- `cyc` deasserting mid-transaction does not abort the AXI transaction. It completes, and the ack is still pulsed.

## Timing

**Reset values** (next edge with `i_rst` = 1)
- State = IDLE.
- All `*valid`, `bready`, `rready`, `o_wb_ack`, `o_bus_err` = 0.
- `o_wb_rdt` = 0.
- Address/data registers = 0.

**Reset mid-transaction**
- Outputs drop at the next edge with no completion.
- The interconnect is reset in the same domain.

**Register and latency rules**
- All AXI outputs and `o_wb_*` are registered. There is no combinational path from input to output.
- Minimum latency, with `cyc` first seen in cycle N:
  - Valids are high in N+1.
  - `bready`/`rready` are high in N+2.
  - If `bvalid`/`rvalid` are already high in N+2, `o_wb_ack` is high in N+3.
  - Back in IDLE in N+4.
- Each cycle of ready/valid stall adds exactly one cycle.
- Back-to-back: a new `cyc` seen in N+4 starts the next transaction; the throughput limit is one access per 4 cycles.
- `o_wb_ack` is exactly one cycle wide and never asserts without a prior `cyc` capture.
- A `bvalid` or `rvalid` arriving while not in WRESP/RDATA is not accepted: `bready`/`rready` stay 0.

## Test plan
- Store, all readies tied high, adr=0x0000_1003, dat=0xDEADBEEF, sel=4'b1000 -> `awaddr`=0x0000_1000, `wstrb`=4'b1000, `wdata`=0xDEADBEEF; `o_wb_ack` at N+3; `o_bus_err`=0.
- Load, adr=0x2000_0010, slave returns `rdata`=0x1234_5678 after 5 stall cycles on `arready` and 3 on `rvalid` -> `o_wb_rdt`=0x1234_5678 in the ack cycle (N+11); `o_wb_rdt` still 0x1234_5678 after a following store.
- Store with `wready` 4 cycles before `awready` (and the reverse order) -> each valid drops only after its own handshake; exactly one `bready` phase; one ack.
- Read returning `rresp`=2'b10 (SLVERR) -> `o_wb_ack` and `o_bus_err` both 1 for exactly one cycle; next access with OKAY gives `o_bus_err`=0.
- SERV core running a load/store loop of 100 random accesses against an AXI memory model with random stalls -> memory contents match the reference model; never more than one outstanding AXI transaction; no AXI protocol-checker violations.
- `i_rst` asserted in WADDR_DATA with `awvalid` high -> next cycle all valids 0, `o_wb_ack` 0, state IDLE; the first access after reset completes normally.

Source files
------------

// File: rtl/serv_dbus_axi_bridge.sv
// rtl/serv_dbus_axi_bridge.sv - SERV Wishbone data bus to single-beat AXI4 master bridge
module serv_dbus_axi_bridge #(
    parameter int unsigned ID_WIDTH = 4,
    parameter int unsigned AXI_ID   = 0
) (
    input  logic                clk,
    input  logic                i_rst,

    input  logic [31:0]         i_wb_adr,
    input  logic [31:0]         i_wb_dat,
    input  logic [3:0]          i_wb_sel,
    input  logic                i_wb_we,
    input  logic                i_wb_cyc,
    output logic [31:0]         o_wb_rdt,
    output logic                o_wb_ack,
    output logic                o_bus_err,

    output logic [ID_WIDTH-1:0] m_axi_awid,
    output logic [31:0]         m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic [2:0]          m_axi_awprot,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,

    output logic [31:0]         m_axi_wdata,
    output logic [3:0]          m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,

    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,

    output logic [ID_WIDTH-1:0] m_axi_arid,
    output logic [31:0]         m_axi_araddr,
    output logic [7:0]          m_axi_arlen,
    output logic [2:0]          m_axi_arsize,
    output logic [1:0]          m_axi_arburst,
    output logic [2:0]          m_axi_arprot,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,

    input  logic [31:0]         m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rlast,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR_DATA,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_ACK
    } state_t;

    state_t      r_state;
    state_t      w_state;

    logic [31:0] r_addr,    w_addr;
    logic [31:0] r_wdata,   w_wdata;
    logic [3:0]  r_wstrb,   w_wstrb;
    logic        r_awvalid, w_awvalid;
    logic        r_wvalid,  w_wvalid;
    logic        r_bready,  w_bready;
    logic        r_arvalid, w_arvalid;
    logic        r_rready,  w_rready;
    logic        r_ack,     w_ack;
    logic        r_err,     w_err;
    logic [31:0] r_rdt,     w_rdt;

    // Single beat only, word aligned; rlast is implied and the low address bits are dropped.
    logic w_unused;
    assign w_unused = &{1'b0, m_axi_rlast, i_wb_adr[1:0]};

    // Register update: every output of the bridge comes straight from a flop.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_rdt     <= '0;
        end else begin
            r_state   <= w_state;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
            r_wstrb   <= w_wstrb;
            r_awvalid <= w_awvalid;
            r_wvalid  <= w_wvalid;
            r_bready  <= w_bready;
            r_arvalid <= w_arvalid;
            r_rready  <= w_rready;
            r_ack     <= w_ack;
            r_err     <= w_err;
            r_rdt     <= w_rdt;
        end
    end

    // Next-state and next-output logic; ack/err default low so they are single-cycle pulses.
    always_comb begin
        w_state   = r_state;
        w_addr    = r_addr;
        w_wdata   = r_wdata;
        w_wstrb   = r_wstrb;
        w_awvalid = r_awvalid;
        w_wvalid  = r_wvalid;
        w_bready  = r_bready;
        w_arvalid = r_arvalid;
        w_rready  = r_rready;
        w_ack     = 1'b0;
        w_err     = 1'b0;
        w_rdt     = r_rdt;

        case (r_state)
            S_IDLE: begin
                if (i_wb_cyc) begin
                    w_addr  = {i_wb_adr[31:2], 2'b00};
                    w_wdata = i_wb_dat;
                    w_wstrb = i_wb_sel;
                    if (i_wb_we) begin
                        w_state   = S_WADDR_DATA;
                        w_awvalid = 1'b1;
                        w_wvalid  = 1'b1;
                    end else begin
                        w_state   = S_RADDR;
                        w_arvalid = 1'b1;
                    end
                end
            end

            S_WADDR_DATA: begin
                // Address and data channels retire independently.
                w_awvalid = r_awvalid & ~m_axi_awready;
                w_wvalid  = r_wvalid  & ~m_axi_wready;
                if (!w_awvalid && !w_wvalid) begin
                    w_state  = S_WRESP;
                    w_bready = 1'b1;
                end
            end

            S_WRESP: begin
                if (m_axi_bvalid) begin
                    w_state  = S_ACK;
                    w_bready = 1'b0;
                    w_ack    = 1'b1;
                    w_err    = (m_axi_bresp != 2'b00);
                end
            end

            S_RADDR: begin
                if (m_axi_arready) begin
                    w_state   = S_RDATA;
                    w_arvalid = 1'b0;
                    w_rready  = 1'b1;
                end
            end

            S_RDATA: begin
                if (m_axi_rvalid) begin
                    w_state  = S_ACK;
                    w_rready = 1'b0;
                    w_ack    = 1'b1;
                    w_err    = (m_axi_rresp != 2'b00);
                    w_rdt    = m_axi_rdata;
                end
            end

            // Guard cycle: cyc is still high here and must not start a new access.
            S_ACK: begin
                w_state = S_IDLE;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign o_wb_rdt      = r_rdt;
    assign o_wb_ack      = r_ack;
    assign o_bus_err     = r_err;

    assign m_axi_awid    = ID_WIDTH'(AXI_ID);
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = r_awvalid;

    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wlast   = 1'b1;
    assign m_axi_wvalid  = r_wvalid;

    assign m_axi_bready  = r_bready;

    assign m_axi_arid    = ID_WIDTH'(AXI_ID);
    assign m_axi_araddr  = r_addr;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = r_arvalid;

    assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_serv_dbus_axi_bridge.sv
// tb/tb_serv_dbus_axi_bridge.sv - directed self-checking bench for serv_dbus_axi_bridge
module tb_serv_dbus_axi_bridge;

    localparam int unsigned ID_WIDTH = 4;
    localparam int unsigned AXI_ID   = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                i_rst;
    logic [31:0]         i_wb_adr;
    logic [31:0]         i_wb_dat;
    logic [3:0]          i_wb_sel;
    logic                i_wb_we;
    logic                i_wb_cyc;
    logic [31:0]         o_wb_rdt;
    logic                o_wb_ack;
    logic                o_bus_err;
    logic [ID_WIDTH-1:0] m_axi_awid;
    logic [31:0]         m_axi_awaddr;
    logic [7:0]          m_axi_awlen;
    logic [2:0]          m_axi_awsize;
    logic [1:0]          m_axi_awburst;
    logic [2:0]          m_axi_awprot;
    logic                m_axi_awvalid;
    logic                m_axi_awready;
    logic [31:0]         m_axi_wdata;
    logic [3:0]          m_axi_wstrb;
    logic                m_axi_wlast;
    logic                m_axi_wvalid;
    logic                m_axi_wready;
    logic [1:0]          m_axi_bresp;
    logic                m_axi_bvalid;
    logic                m_axi_bready;
    logic [ID_WIDTH-1:0] m_axi_arid;
    logic [31:0]         m_axi_araddr;
    logic [7:0]          m_axi_arlen;
    logic [2:0]          m_axi_arsize;
    logic [1:0]          m_axi_arburst;
    logic [2:0]          m_axi_arprot;
    logic                m_axi_arvalid;
    logic                m_axi_arready;
    logic [31:0]         m_axi_rdata;
    logic [1:0]          m_axi_rresp;
    logic                m_axi_rlast;
    logic                m_axi_rvalid;
    logic                m_axi_rready;

    serv_dbus_axi_bridge #(
        .ID_WIDTH (ID_WIDTH),
        .AXI_ID   (AXI_ID)
    ) dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_wb_adr      (i_wb_adr),
        .i_wb_dat      (i_wb_dat),
        .i_wb_sel      (i_wb_sel),
        .i_wb_we       (i_wb_we),
        .i_wb_cyc      (i_wb_cyc),
        .o_wb_rdt      (o_wb_rdt),
        .o_wb_ack      (o_wb_ack),
        .o_bus_err     (o_bus_err),
        .m_axi_awid    (m_axi_awid),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_acks   = 0;
    int acks0;

    always @(posedge clk) begin
        if (o_wb_ack) n_acks <= n_acks + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
        i_wb_cyc = 1'b1;
        i_wb_we  = we;
        i_wb_adr = adr;
        i_wb_dat = dat;
        i_wb_sel = sel;
    endtask

    // Store with all readies high; returns in N+4 with cyc dropped.
    task automatic quick_store(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input logic [1:0] bresp);
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        m_axi_bvalid  = 1'b1;
        m_axi_bresp   = bresp;
        req(1'b1, adr, dat, sel);
        tick();
        chk({tag, "_awaddr"}, m_axi_awaddr, {adr[31:2], 2'b00});
        chk({tag, "_wdata"}, m_axi_wdata, dat);
        tick();
        tick();
        chk({tag, "_ack"}, 32'(o_wb_ack), 32'd1);
        chk({tag, "_err"}, 32'(o_bus_err), (bresp != 2'b00) ? 32'd1 : 32'd0);
        m_axi_bvalid  = 1'b0;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        tick();
        i_wb_cyc = 1'b0;
    endtask

    // Load with all readies high; returns in N+4 with cyc dropped.
    task automatic quick_load(input string tag, input logic [31:0] adr, input logic [31:0] rdata,
                              input logic [1:0] rresp);
        m_axi_arready = 1'b1;
        m_axi_rvalid  = 1'b1;
        m_axi_rdata   = rdata;
        m_axi_rresp   = rresp;
        req(1'b0, adr, 32'h0, 4'h0);
        tick();
        chk({tag, "_arvalid"}, 32'(m_axi_arvalid), 32'd1);
        chk({tag, "_araddr"}, m_axi_araddr, {adr[31:2], 2'b00});
        tick();
        tick();
        chk({tag, "_ack"}, 32'(o_wb_ack), 32'd1);
        chk({tag, "_rdt"}, o_wb_rdt, rdata);
        chk({tag, "_err"}, 32'(o_bus_err), (rresp != 2'b00) ? 32'd1 : 32'd0);
        m_axi_rvalid  = 1'b0;
        m_axi_arready = 1'b0;
        tick();
        i_wb_cyc = 1'b0;
    endtask

    // Store where one channel's ready arrives 4 cycles before the other.
    task automatic store_order(input logic w_first);
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        acks0 = n_acks;
        req(1'b1, 32'h0000_3008, 32'hA5A5_0F0F, 4'b0011);
        tick();
        chk("ord_awvalid_n1", 32'(m_axi_awvalid), 32'd1);
        chk("ord_wvalid_n1", 32'(m_axi_wvalid), 32'd1);
        chk("ord_wstrb", 32'(m_axi_wstrb), 32'h3);
        if (w_first) m_axi_wready = 1'b1;
        else         m_axi_awready = 1'b1;
        tick();
        m_axi_wready  = 1'b0;
        m_axi_awready = 1'b0;
        chk("ord_first_drop", 32'(w_first ? m_axi_wvalid : m_axi_awvalid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("ord_other_hold", 32'(w_first ? m_axi_awvalid : m_axi_wvalid), 32'd1);
            chk("ord_bready_early", 32'(m_axi_bready), 32'd0);
            tick();
        end
        chk("ord_other_hold_n5", 32'(w_first ? m_axi_awvalid : m_axi_wvalid), 32'd1);
        if (w_first) m_axi_awready = 1'b1;
        else         m_axi_wready = 1'b1;
        tick();
        m_axi_wready  = 1'b0;
        m_axi_awready = 1'b0;
        chk("ord_awvalid_done", 32'(m_axi_awvalid), 32'd0);
        chk("ord_wvalid_done", 32'(m_axi_wvalid), 32'd0);
        chk("ord_bready", 32'(m_axi_bready), 32'd1);
        m_axi_bvalid = 1'b1;
        tick();
        m_axi_bvalid = 1'b0;
        chk("ord_ack", 32'(o_wb_ack), 32'd1);
        chk("ord_bready_off", 32'(m_axi_bready), 32'd0);
        tick();
        i_wb_cyc = 1'b0;
        chk("ord_ack_off", 32'(o_wb_ack), 32'd0);
        chk("ord_bready_once", 32'(m_axi_bready), 32'd0);
        chk("ord_ack_count", 32'(n_acks - acks0), 32'd1);
    endtask

    initial begin
        i_rst = 1'b1;
        i_wb_adr = '0; i_wb_dat = '0; i_wb_sel = '0; i_wb_we = 1'b0; i_wb_cyc = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b1; m_axi_rvalid = 1'b0;
        tick();
        tick();

        // Reset state and constant fields
        chk("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
        chk("rst_wvalid", 32'(m_axi_wvalid), 32'd0);
        chk("rst_arvalid", 32'(m_axi_arvalid), 32'd0);
        chk("rst_bready", 32'(m_axi_bready), 32'd0);
        chk("rst_rready", 32'(m_axi_rready), 32'd0);
        chk("rst_ack", 32'(o_wb_ack), 32'd0);
        chk("rst_err", 32'(o_bus_err), 32'd0);
        chk("rst_rdt", o_wb_rdt, 32'h0);
        chk("rst_awaddr", m_axi_awaddr, 32'h0);
        chk("const_awlen", 32'(m_axi_awlen), 32'd0);
        chk("const_arlen", 32'(m_axi_arlen), 32'd0);
        chk("const_awsize", 32'(m_axi_awsize), 32'd2);
        chk("const_arsize", 32'(m_axi_arsize), 32'd2);
        chk("const_awburst", 32'(m_axi_awburst), 32'd1);
        chk("const_arburst", 32'(m_axi_arburst), 32'd1);
        chk("const_awprot", 32'(m_axi_awprot), 32'd0);
        chk("const_arprot", 32'(m_axi_arprot), 32'd0);
        chk("const_wlast", 32'(m_axi_wlast), 32'd1);
        chk("const_awid", 32'(m_axi_awid), 32'd5);
        chk("const_arid", 32'(m_axi_arid), 32'd5);
        i_rst = 1'b0;
        tick();

        // Store, readies high, bvalid already pending before WRESP
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        acks0 = n_acks;
        req(1'b1, 32'h0000_1003, 32'hDEAD_BEEF, 4'b1000);
        tick();
        chk("st_awvalid", 32'(m_axi_awvalid), 32'd1);
        chk("st_wvalid", 32'(m_axi_wvalid), 32'd1);
        chk("st_awaddr", m_axi_awaddr, 32'h0000_1000);
        chk("st_wdata", m_axi_wdata, 32'hDEAD_BEEF);
        chk("st_wstrb", 32'(m_axi_wstrb), 32'h8);
        chk("st_bready_n1", 32'(m_axi_bready), 32'd0);
        chk("st_ack_n1", 32'(o_wb_ack), 32'd0);
        tick();
        chk("st_awvalid_n2", 32'(m_axi_awvalid), 32'd0);
        chk("st_wvalid_n2", 32'(m_axi_wvalid), 32'd0);
        chk("st_bready_n2", 32'(m_axi_bready), 32'd1);
        chk("st_ack_n2", 32'(o_wb_ack), 32'd0);
        tick();
        chk("st_ack_n3", 32'(o_wb_ack), 32'd1);
        chk("st_err_n3", 32'(o_bus_err), 32'd0);
        chk("st_bready_n3", 32'(m_axi_bready), 32'd0);
        m_axi_bvalid = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        tick();
        i_wb_cyc = 1'b0;
        chk("st_ack_n4", 32'(o_wb_ack), 32'd0);
        tick();
        chk("st_no_retrig", 32'(m_axi_awvalid), 32'd0);
        chk("st_ack_count", 32'(n_acks - acks0), 32'd1);

        // Load with 5 arready stalls and 3 rvalid stalls: ack in N+11
        req(1'b0, 32'h2000_0010, 32'h0, 4'h0);
        tick();
        i_wb_adr = 32'hFFFF_FFFC;
        i_wb_we  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("ld_arvalid_stall", 32'(m_axi_arvalid), 32'd1);
            chk("ld_araddr_stable", m_axi_araddr, 32'h2000_0010);
            tick();
        end
        m_axi_arready = 1'b1;
        chk("ld_rready_early", 32'(m_axi_rready), 32'd0);
        tick();
        m_axi_arready = 1'b0;
        chk("ld_arvalid_done", 32'(m_axi_arvalid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("ld_rready_stall", 32'(m_axi_rready), 32'd1);
            chk("ld_ack_stall", 32'(o_wb_ack), 32'd0);
            tick();
        end
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'h1234_5678; m_axi_rresp = 2'b00;
        chk("ld_no_awvalid", 32'(m_axi_awvalid), 32'd0);
        tick();
        m_axi_rvalid = 1'b0;
        chk("ld_ack_n11", 32'(o_wb_ack), 32'd1);
        chk("ld_rdt_n11", o_wb_rdt, 32'h1234_5678);
        chk("ld_err_n11", 32'(o_bus_err), 32'd0);
        tick();
        i_wb_cyc = 1'b0;
        m_axi_rdata = 32'h0;
        quick_store("st2", 32'h0000_0040, 32'h0102_0304, 4'hF, 2'b00);
        chk("ld_rdt_held", o_wb_rdt, 32'h1234_5678);

        // Write channel ordering, both ways
        store_order(1'b1);
        store_order(1'b0);

        // Error responses
        quick_load("slverr", 32'h4000_0000, 32'hCAFE_F00D, 2'b10);
        chk("slverr_ack_1cyc", 32'(o_wb_ack), 32'd0);
        chk("slverr_err_1cyc", 32'(o_bus_err), 32'd0);
        quick_load("okay_after", 32'h4000_0004, 32'h1111_2222, 2'b00);
        quick_store("decerr", 32'h4000_0008, 32'h3333_4444, 4'b0101, 2'b11);

        // Reset in WADDR_DATA with awvalid high
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        req(1'b1, 32'h5000_0004, 32'h5555_AAAA, 4'hF);
        tick();
        chk("rst_mid_awvalid_pre", 32'(m_axi_awvalid), 32'd1);
        i_rst = 1'b1;
        tick();
        chk("rst_mid_awvalid", 32'(m_axi_awvalid), 32'd0);
        chk("rst_mid_wvalid", 32'(m_axi_wvalid), 32'd0);
        chk("rst_mid_arvalid", 32'(m_axi_arvalid), 32'd0);
        chk("rst_mid_bready", 32'(m_axi_bready), 32'd0);
        chk("rst_mid_ack", 32'(o_wb_ack), 32'd0);
        chk("rst_mid_awaddr", m_axi_awaddr, 32'h0);
        chk("rst_mid_rdt", o_wb_rdt, 32'h0);
        i_rst = 1'b0;
        i_wb_cyc = 1'b0;
        tick();
        chk("rst_mid_idle", 32'(m_axi_awvalid), 32'd0);
        quick_load("post_rst", 32'h6000_0008, 32'h0BAD_F00D, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
